// File: rtl/top.sv
// RV32I five-stage pipelined core (IF/ID/EX/MEM/WB) with byte-addressed instruction and data memories.
// Build option: define TOP_FORWARDING_EN for EX operand forwarding; without it, ID interlocks on EX/MEM producers.

module rv_imem (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [15:0] waddr_i,
    input  logic [7:0]  wdata_i,
    input  logic [15:0] addr_i,
    output logic [31:0] rdata_o
);
    logic [7:0] mem [0:65535];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = {mem[addr_i + 16'd3], mem[addr_i + 16'd2], mem[addr_i + 16'd1], mem[addr_i]};
endmodule

module rv_dmem (
    input  logic        clk_i,
    input  logic [3:0]  be_i,
    input  logic [15:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);
    logic [7:0] mem [0:65535];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) mem[addr_i + 16'(i)] <= wdata_i[8*i +: 8];
        end
    end

    assign rdata_o = {mem[addr_i + 16'd3], mem[addr_i + 16'd2], mem[addr_i + 16'd1], mem[addr_i]};
endmodule

module rv_reg_file (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) registers[i] <= '0;
        end else if (we_i && wa_i != 5'd0) begin
            registers[wa_i] <= wd_i;
        end
    end

    // WB write is visible to an ID read in the same cycle.
    always_comb begin
        rd1_o = registers[ra1_i];
        if (ra1_i == 5'd0)                 rd1_o = '0;
        else if (we_i && wa_i == ra1_i)    rd1_o = wd_i;
        rd2_o = registers[ra2_i];
        if (ra2_i == 5'd0)                 rd2_o = '0;
        else if (we_i && wa_i == ra2_i)    rd2_o = wd_i;
    end
endmodule

module top (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;

    function automatic logic writes_rd(input logic [31:0] ins);
        logic w;
        case (ins[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_REG: w = (ins[11:7] != 5'd0);
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ins);
        logic u;
        case (ins[6:0])
            OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_REG: u = 1'b1;
            default: u = 1'b0;
        endcase
        return u;
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        return (ins[6:0] == OP_BR) || (ins[6:0] == OP_ST) || (ins[6:0] == OP_REG);
    endfunction

    logic [31:0] pc_q;
    logic        ifid_valid_q;
    logic [31:0] ifid_pc_q, ifid_instr_q;
    logic        idex_valid_q;
    logic [31:0] idex_pc_q, idex_instr_q, idex_rs1v_q, idex_rs2v_q;
    logic        exmem_we_q, exmem_ld_q, exmem_st_q;
    logic [4:0]  exmem_rd_q;
    logic [2:0]  exmem_f3_q;
    logic [31:0] exmem_result_q, exmem_rs2v_q;
    logic        memwb_we_q;
    logic [4:0]  memwb_rd_q;
    logic [31:0] memwb_data_q;

    logic [31:0] if_instr, id_rs1v, id_rs2v, dm_rdata;
    logic [3:0]  dm_be;

    rv_imem im (
        .clk_i(clk), .we_i(1'b0), .waddr_i(16'd0), .wdata_i(8'd0),
        .addr_i(pc_q[15:0]), .rdata_o(if_instr)
    );

    rv_reg_file reg_file (
        .clk_i(clk), .rst_ni(rst),
        .ra1_i(ifid_instr_q[19:15]), .ra2_i(ifid_instr_q[24:20]),
        .we_i(memwb_we_q), .wa_i(memwb_rd_q), .wd_i(memwb_data_q),
        .rd1_o(id_rs1v), .rd2_o(id_rs2v)
    );

    rv_dmem dm (
        .clk_i(clk), .be_i(dm_be), .addr_i(exmem_result_q[15:0]),
        .wdata_i(exmem_rs2v_q), .rdata_o(dm_rdata)
    );

    // EX decode
    logic [6:0]  ex_op;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd;
    logic        ex_wr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] ex_a, ex_rs2f, ex_b, ex_alu, ex_result, ex_target;
    logic        ex_cond, ex_take;

    assign ex_op = idex_instr_q[6:0];
    assign ex_f3 = idex_instr_q[14:12];
    assign ex_rd = idex_instr_q[11:7];
    assign ex_wr = idex_valid_q && writes_rd(idex_instr_q);
    assign imm_i = {{20{idex_instr_q[31]}}, idex_instr_q[31:20]};
    assign imm_s = {{20{idex_instr_q[31]}}, idex_instr_q[31:25], idex_instr_q[11:7]};
    assign imm_b = {{19{idex_instr_q[31]}}, idex_instr_q[31], idex_instr_q[7],
                    idex_instr_q[30:25], idex_instr_q[11:8], 1'b0};
    assign imm_u = {idex_instr_q[31:12], 12'b0};
    assign imm_j = {{11{idex_instr_q[31]}}, idex_instr_q[31], idex_instr_q[19:12],
                    idex_instr_q[20], idex_instr_q[30:21], 1'b0};

`ifdef TOP_FORWARDING_EN
    logic [4:0] ex_rs1, ex_rs2;
    assign ex_rs1 = idex_instr_q[19:15];
    assign ex_rs2 = idex_instr_q[24:20];

    // MEM-stage result is younger than WB, so it wins.
    always_comb begin
        ex_a = idex_rs1v_q;
        if (exmem_we_q && exmem_rd_q == ex_rs1)      ex_a = exmem_result_q;
        else if (memwb_we_q && memwb_rd_q == ex_rs1) ex_a = memwb_data_q;
        ex_rs2f = idex_rs2v_q;
        if (exmem_we_q && exmem_rd_q == ex_rs2)      ex_rs2f = exmem_result_q;
        else if (memwb_we_q && memwb_rd_q == ex_rs2) ex_rs2f = memwb_data_q;
    end
`else
    assign ex_a    = idex_rs1v_q;
    assign ex_rs2f = idex_rs2v_q;
`endif

    assign ex_b = (ex_op == OP_REG) ? ex_rs2f : ((ex_op == OP_ST) ? imm_s : imm_i);

    always_comb begin
        ex_alu = '0;
        case (ex_f3)
            3'b000: ex_alu = (ex_op == OP_REG && idex_instr_q[30]) ? ex_a - ex_b : ex_a + ex_b;
            3'b001: ex_alu = ex_a << ex_b[4:0];
            3'b010: ex_alu = {31'd0, $signed(ex_a) < $signed(ex_b)};
            3'b011: ex_alu = {31'd0, ex_a < ex_b};
            3'b100: ex_alu = ex_a ^ ex_b;
            3'b101: ex_alu = idex_instr_q[30] ? 32'($signed(ex_a) >>> ex_b[4:0]) : ex_a >> ex_b[4:0];
            3'b110: ex_alu = ex_a | ex_b;
            default: ex_alu = ex_a & ex_b;
        endcase

        case (ex_op)
            OP_LUI:          ex_result = imm_u;
            OP_AUIPC:        ex_result = idex_pc_q + imm_u;
            OP_JAL, OP_JALR: ex_result = idex_pc_q + 32'd4;
            OP_LD, OP_ST:    ex_result = ex_a + ex_b;
            default:         ex_result = ex_alu;
        endcase

        case (ex_f3)
            3'b000:  ex_cond = (ex_a == ex_rs2f);
            3'b001:  ex_cond = (ex_a != ex_rs2f);
            3'b100:  ex_cond = ($signed(ex_a) < $signed(ex_rs2f));
            3'b101:  ex_cond = ($signed(ex_a) >= $signed(ex_rs2f));
            3'b110:  ex_cond = (ex_a < ex_rs2f);
            3'b111:  ex_cond = (ex_a >= ex_rs2f);
            default: ex_cond = 1'b0;
        endcase

        ex_take = idex_valid_q && ((ex_op == OP_BR && ex_cond) || ex_op == OP_JAL || ex_op == OP_JALR);
        if (ex_op == OP_JALR) ex_target = (ex_a + imm_i) & ~32'd1;
        else                  ex_target = idex_pc_q + ((ex_op == OP_JAL) ? imm_j : imm_b);
    end

    // ID hazard detection
    logic [4:0] id_rs1, id_rs2;
    logic       id_u1, id_u2, stall;
    assign id_rs1 = ifid_instr_q[19:15];
    assign id_rs2 = ifid_instr_q[24:20];
    assign id_u1  = uses_rs1(ifid_instr_q);
    assign id_u2  = uses_rs2(ifid_instr_q);

`ifdef TOP_FORWARDING_EN
    assign stall = ifid_valid_q && ex_wr && (ex_op == OP_LD) &&
                   ((id_u1 && ex_rd == id_rs1) || (id_u2 && ex_rd == id_rs2));
`else
    assign stall = ifid_valid_q &&
                   ((id_u1 && ((ex_wr && ex_rd == id_rs1) || (exmem_we_q && exmem_rd_q == id_rs1))) ||
                    (id_u2 && ((ex_wr && ex_rd == id_rs2) || (exmem_we_q && exmem_rd_q == id_rs2))));
`endif

    // MEM access
    logic [31:0] mem_ld;
    always_comb begin
        dm_be = 4'b0000;
        if (exmem_st_q) begin
            case (exmem_f3_q[1:0])
                2'b00:   dm_be = 4'b0001;
                2'b01:   dm_be = 4'b0011;
                default: dm_be = 4'b1111;
            endcase
        end
        case (exmem_f3_q)
            3'b000:  mem_ld = {{24{dm_rdata[7]}}, dm_rdata[7:0]};
            3'b001:  mem_ld = {{16{dm_rdata[15]}}, dm_rdata[15:0]};
            3'b100:  mem_ld = {24'd0, dm_rdata[7:0]};
            3'b101:  mem_ld = {16'd0, dm_rdata[15:0]};
            default: mem_ld = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q           <= '0;
            ifid_valid_q   <= 1'b0;
            ifid_pc_q      <= '0;
            ifid_instr_q   <= '0;
            idex_valid_q   <= 1'b0;
            idex_pc_q      <= '0;
            idex_instr_q   <= '0;
            idex_rs1v_q    <= '0;
            idex_rs2v_q    <= '0;
            exmem_we_q     <= 1'b0;
            exmem_ld_q     <= 1'b0;
            exmem_st_q     <= 1'b0;
            exmem_rd_q     <= '0;
            exmem_f3_q     <= '0;
            exmem_result_q <= '0;
            exmem_rs2v_q   <= '0;
            memwb_we_q     <= 1'b0;
            memwb_rd_q     <= '0;
            memwb_data_q   <= '0;
        end else begin
            // A taken branch squashes ID and IF even when ID would otherwise stall.
            if (ex_take) begin
                pc_q         <= ex_target;
                ifid_valid_q <= 1'b0;
                idex_valid_q <= 1'b0;
            end else if (stall) begin
                idex_valid_q <= 1'b0;
            end else begin
                pc_q         <= pc_q + 32'd4;
                ifid_valid_q <= 1'b1;
                ifid_pc_q    <= pc_q;
                ifid_instr_q <= if_instr;
                idex_valid_q <= ifid_valid_q;
                idex_pc_q    <= ifid_pc_q;
                idex_instr_q <= ifid_instr_q;
                idex_rs1v_q  <= id_rs1v;
                idex_rs2v_q  <= id_rs2v;
            end

            exmem_we_q     <= ex_wr;
            exmem_ld_q     <= idex_valid_q && ex_op == OP_LD;
            exmem_st_q     <= idex_valid_q && ex_op == OP_ST;
            exmem_rd_q     <= ex_rd;
            exmem_f3_q     <= ex_f3;
            exmem_result_q <= ex_result;
            exmem_rs2v_q   <= ex_rs2f;

            memwb_we_q     <= exmem_we_q;
            memwb_rd_q     <= exmem_rd_q;
            memwb_data_q   <= exmem_ld_q ? mem_ld : exmem_result_q;
        end
    end
endmodule

// File: tb/tb_top.sv
// Self-checking bench for the RV32I pipeline: programs are assembled into im, expected memory words are
// queued as stores are emitted and compared against dm once the program has drained.

module tb_top;
    logic clk, rst;

    top dut (.clk(clk), .rst(rst));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic [31:0] val;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    exp_t        sb[$];
    alu_vec_t    vecs[10];
    logic [31:0] prog[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          t3 = -1;
    int          t4 = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && dut.memwb_we_q) begin
            if (dut.memwb_rd_q == 5'd3) t3 = cyc;
            if (dut.memwb_rd_q == 5'd4) t4 = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dm_word(input logic [15:0] a);
        return {dut.dm.mem[a + 16'd3], dut.dm.mem[a + 16'd2], dut.dm.mem[a + 16'd1], dut.dm.mem[a]};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] v, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] v, input logic [4:0] rd);
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    task automatic emit(input logic [31:0] w);
        prog.push_back(w);
    endtask

    task automatic li(input logic [4:0] rd, input logic [31:0] val);
        logic [31:0] hi;
        hi = (val + 32'h800) >> 12;
        emit(enc_u(hi[19:0], rd, LUI));
        emit(enc_i(val, rd, 3'd0, rd, OPIMM));
    endtask

    // Store rs2 at 0x9000+off through base x10 and queue the word expected there afterwards.
    task automatic st_exp(input logic [4:0] rs2, input logic [11:0] off, input logic [2:0] f3,
                          input string name, input logic [31:0] val);
        emit(enc_s(off, rs2, 5'd10, f3));
        sb.push_back(exp_t'{name, 16'h9000 + 16'(off), val});
    endtask

    task automatic load_prog();
        logic [31:0] w;
        for (int i = 0; i < prog.size(); i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) dut.im.mem[16'(4*i + k)] = w[8*k +: 8];
        end
    endtask

    task automatic restart(input int n);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        t3 = -1;
        t4 = -1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, dm_word(e.addr), e.val);
        end
    endtask

    initial begin
        vecs[0] = alu_vec_t'{"add",  3'd0, 7'h00, 32'd5,         32'd7,         32'd12};
        vecs[1] = alu_vec_t'{"sub",  3'd0, 7'h20, 32'd5,         32'd7,         32'hFFFFFFFE};
        vecs[2] = alu_vec_t'{"sll",  3'd1, 7'h00, 32'd1,         32'd35,        32'd8};
        vecs[3] = alu_vec_t'{"srl",  3'd5, 7'h00, 32'h80000000,  32'd4,         32'h08000000};
        vecs[4] = alu_vec_t'{"sra",  3'd5, 7'h20, 32'h80000000,  32'd4,         32'hF8000000};
        vecs[5] = alu_vec_t'{"slt",  3'd2, 7'h00, 32'hFFFFFFFF,  32'd1,         32'd1};
        vecs[6] = alu_vec_t'{"sltu", 3'd3, 7'h00, 32'hFFFFFFFF,  32'd1,         32'd0};
        vecs[7] = alu_vec_t'{"xor",  3'd4, 7'h00, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFF00FF00};
        vecs[8] = alu_vec_t'{"or",   3'd6, 7'h00, 32'h00FF0000,  32'h000000FF,  32'h00FF00FF};
        vecs[9] = alu_vec_t'{"and",  3'd7, 7'h00, 32'h12345678,  32'h0000FFFF,  32'h00005678};

        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("reset_pc", dut.pc_q, 32'd0);
        check("reset_ifid_valid", {31'd0, dut.ifid_valid_q}, 32'd0);
        check("reset_idex_valid", {31'd0, dut.idex_valid_q}, 32'd0);
        check("reset_x5", dut.reg_file.registers[5], 32'd0);

        // Program 1: dependency chain, load/store widths, load-use, branches.
        prog.delete();
        emit(enc_i(5, 0, 3'd0, 1, OPIMM));
        emit(enc_i(-7, 1, 3'd0, 2, OPIMM));
        emit(enc_u(20'h9, 10, LUI));
        st_exp(2, 12'h000, 3'd2, "dep_chain", 32'hFFFFFFFE);
        li(6, 32'h80008081);
        st_exp(6, 12'h004, 3'd2, "sw_word", 32'h80008081);
        emit(enc_i(4, 10, 3'd0, 7, LOAD));
        st_exp(7, 12'h008, 3'd2, "lb", 32'hFFFFFF81);
        emit(enc_i(4, 10, 3'd4, 7, LOAD));
        st_exp(7, 12'h00C, 3'd2, "lbu", 32'h00000081);
        emit(enc_i(4, 10, 3'd1, 7, LOAD));
        st_exp(7, 12'h010, 3'd2, "lh", 32'hFFFF8081);
        emit(enc_i(4, 10, 3'd5, 7, LOAD));
        st_exp(7, 12'h014, 3'd2, "lhu", 32'h00008081);
        emit(enc_s(12'h018, 0, 10, 3'd2));
        st_exp(6, 12'h018, 3'd1, "sh_2bytes", 32'h00008081);
        emit(enc_s(12'h01C, 0, 10, 3'd2));
        st_exp(6, 12'h01C, 3'd0, "sb_1byte", 32'h00000081);
        emit(enc_i(32'h11, 0, 3'd0, 5, OPIMM));
        emit(enc_s(12'h200, 5, 10, 3'd2));
        emit(enc_i(32'h200, 10, 3'd2, 3, LOAD));
        emit(enc_r(7'h00, 3, 3, 3'd0, 4));
        st_exp(4, 12'h204, 3'd2, "load_use", 32'h22);
        emit(enc_i(1, 0, 3'd0, 5, OPIMM));
        emit(enc_b(12, 0, 0, 3'd0));
        emit(enc_i(1, 5, 3'd0, 5, OPIMM));
        emit(enc_i(1, 5, 3'd0, 5, OPIMM));
        st_exp(5, 12'h208, 3'd2, "beq_skip", 32'd1);
        emit(enc_b(8, 0, 0, 3'd1));
        emit(enc_i(2, 5, 3'd0, 5, OPIMM));
        st_exp(5, 12'h220, 3'd2, "bne_fall", 32'd3);
        emit(enc_i(-1, 0, 3'd0, 8, OPIMM));
        emit(enc_b(8, 0, 8, 3'd4));
        emit(enc_i(4, 5, 3'd0, 5, OPIMM));
        st_exp(5, 12'h224, 3'd2, "blt_taken", 32'd3);
        emit(enc_j(0, 0));
        load_prog();
        restart(300);
        drain_sb();
        check("x4_load_use", dut.reg_file.registers[4], 32'h22);
`ifdef TOP_FORWARDING_EN
        check("load_use_wb_gap", t4 - t3, 32'd2);
`else
        check("load_use_wb_gap", t4 - t3, 32'd3);
`endif

        // Program 2: x0, FENCE/ECALL, AUIPC, JAL at 0x20, JALR, final SB to 0xFFFC, mid-run reset.
        prog.delete();
        emit(enc_i(5, 0, 3'd0, 0, OPIMM));
        emit(32'h0000000F);
        emit(32'h00000073);
        emit(enc_u(20'h9, 10, LUI));
        emit(enc_u(20'h1, 14, AUIPC));
        emit(enc_i(7, 0, 3'd0, 12, OPIMM));
        emit(enc_r(7'h00, 0, 0, 3'd0, 12));
        emit(enc_i(32'h35, 0, 3'd0, 15, OPIMM));
        emit(enc_j(8, 1));
        emit(enc_i(32'h7FF, 0, 3'd0, 1, OPIMM));
        st_exp(1, 12'h20C, 3'd2, "jal_link", 32'h24);
        emit(enc_i(0, 15, 3'd0, 16, JALR));
        emit(enc_i(0, 0, 3'd0, 16, OPIMM));
        st_exp(16, 12'h210, 3'd2, "jalr_link", 32'h30);
        st_exp(14, 12'h214, 3'd2, "auipc", 32'h1010);
        st_exp(12, 12'h218, 3'd2, "x0_read", 32'd0);
        emit(enc_i(-1, 0, 3'd0, 13, OPIMM));
        emit(enc_i(-4, 0, 3'd0, 11, OPIMM));
        emit(enc_s(12'h000, 13, 11, 3'd0));
        emit(enc_j(0, 0));
        load_prog();
        restart(20);
        check("pre_reset_x14", dut.reg_file.registers[14], 32'h1010);
        rst = 1'b0;
        #1;
        check("midrun_reset_pc", dut.pc_q, 32'd0);
        check("midrun_reset_ifid", {31'd0, dut.ifid_valid_q}, 32'd0);
        check("midrun_reset_idex", {31'd0, dut.idex_valid_q}, 32'd0);
        check("midrun_reset_x14", dut.reg_file.registers[14], 32'd0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("first_fetch_pc", dut.ifid_pc_q, 32'd0);
        check("first_fetch_valid", {31'd0, dut.ifid_valid_q}, 32'd1);
        check("pc_after_first_fetch", dut.pc_q, 32'd4);
        repeat (200) @(negedge clk);
        drain_sb();
        check("x0_zero", dut.reg_file.registers[0], 32'd0);
        check("x1_jal", dut.reg_file.registers[1], 32'h24);
        check("sb_ffc", {24'd0, dut.dm.mem[16'hFFFC]}, 32'h000000FF);

        // Program 3: register-register ALU table plus a few immediate forms.
        prog.delete();
        emit(enc_u(20'h9, 10, LUI));
        for (int i = 0; i < 10; i++) begin
            li(1, vecs[i].a);
            li(2, vecs[i].b);
            emit(enc_r(vecs[i].f7, 2, 1, vecs[i].f3, 3));
            st_exp(3, 12'(12'h100 + 4*i), 3'd2, vecs[i].name, vecs[i].exp);
        end
        li(1, 32'h80000000);
        emit(enc_i({20'd0, 7'h20, 5'd4}, 1, 3'd5, 3, OPIMM));
        st_exp(3, 12'h140, 3'd2, "srai", 32'hF8000000);
        emit(enc_i(1, 0, 3'd3, 3, OPIMM));
        st_exp(3, 12'h144, 3'd2, "sltiu", 32'd1);
        emit(enc_j(0, 0));
        load_prog();
        restart(500);
        drain_sb();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
